// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_TX among NUM_REQ byte producers.
// Each grant owns the transmitter for one frame; a busy-timeout recovers from a dead transmitter.
module uart_tx_arbiter #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ack,
    output logic [DATA_WIDTH-1:0]           tx_p_data,
    output logic                            tx_data_valid,
    input  logic                            tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            active,
    output logic                            timeout_err
);
    localparam int IDW  = $clog2(NUM_REQ);
    localparam int CNTW = $clog2(BUSY_TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t                               state, state_n;
    logic [IDW-1:0]                       ptr, ptr_n, win, gid_n, next_ptr;
    logic [CNTW-1:0]                      cnt, cnt_n;
    logic [NUM_REQ-1:0]                   ack_n;
    logic                                 dv_n, active_n, to_n;
    logic [DATA_WIDTH-1:0]                pdata_n;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_word;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_word[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDW'(s);
    endfunction

    // Scan from the far end so the closest requester at or after ptr wins last.
    always_comb begin
        win = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[rr_idx(ptr, k)]) win = rr_idx(ptr, k);
        end
    end

    assign next_ptr = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + IDW'(1);

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        cnt_n    = cnt;
        ack_n    = '0;
        dv_n     = 1'b0;
        to_n     = 1'b0;
        active_n = active;
        pdata_n  = tx_p_data;
        gid_n    = grant_id;
        case (state)
            IDLE: begin
                if (!tx_busy && |req_valid) begin
                    ack_n[win] = 1'b1;
                    dv_n       = 1'b1;
                    active_n   = 1'b1;
                    pdata_n    = req_word[win];
                    gid_n      = win;
                    state_n    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_n   = '0;
                state_n = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_n = WAIT_DONE;
                end else if (cnt == CNTW'(BUSY_TIMEOUT - 1)) begin
                    // Transmitter never took the byte: give up and move past this requester.
                    to_n     = 1'b1;
                    active_n = 1'b0;
                    ptr_n    = next_ptr;
                    state_n  = IDLE;
                end else begin
                    cnt_n = cnt + CNTW'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    active_n = 1'b0;
                    ptr_n    = next_ptr;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state         <= IDLE;
            ptr           <= '0;
            cnt           <= '0;
            req_ack       <= '0;
            tx_data_valid <= 1'b0;
            timeout_err   <= 1'b0;
            active        <= 1'b0;
            tx_p_data     <= '0;
            grant_id      <= '0;
        end else begin
            state         <= state_n;
            ptr           <= ptr_n;
            cnt           <= cnt_n;
            req_ack       <= ack_n;
            tx_data_valid <= dv_n;
            timeout_err   <= to_n;
            active        <= active_n;
            tx_p_data     <= pdata_n;
            grant_id      <= gid_n;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vector table, hand-written corner sequences,
// then randomized traffic against a transaction-rule reference model.
module tb_uart_tx_arbiter;
    localparam int DW = 8;
    localparam int N  = 4;
    localparam int BT = 16;
    localparam int IW = 2;
    localparam int FL = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic [N-1:0]  req_valid;
    logic [N*DW-1:0] req_data;
    logic          tx_busy;
    logic [N-1:0]  req_ack;
    logic [DW-1:0] tx_p_data;
    logic          tx_data_valid;
    logic [IW-1:0] grant_id;
    logic          active;
    logic          timeout_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    uart_tx_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .BUSY_TIMEOUT(BT)) dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_data(req_data),
        .req_ack(req_ack), .tx_p_data(tx_p_data), .tx_data_valid(tx_data_valid),
        .tx_busy(tx_busy), .grant_id(grant_id), .active(active), .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic rst; logic [N-1:0] rv; logic busy;
        logic [N-1:0] ack; logic dv; logic [DW-1:0] pd; logic [IW-1:0] gid; logic act; logic to;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic [N-1:0] rv, input logic busy,
                                input logic [N-1:0] ack, input logic dv, input logic [DW-1:0] pd,
                                input logic [IW-1:0] gid, input logic act, input logic to);
        vec_t v;
        v.rst = rst; v.rv = rv; v.busy = busy; v.ack = ack; v.dv = dv;
        v.pd = pd; v.gid = gid; v.act = act; v.to = to;
        return v;
    endfunction

    // Reference model: phase 0 free, 1 byte offered, 2 awaiting busy, 3 frame running
    int            m_ptr, m_phase, m_wait;
    logic [N-1:0]  e_ack;
    logic          e_dv, e_act, e_to;
    logic [DW-1:0] e_pd;
    logic [IW-1:0] e_gid;

    task automatic model_step();
        int w;
        e_ack = '0; e_dv = 1'b0; e_to = 1'b0;
        if (!RST) begin
            m_ptr = 0; m_phase = 0; m_wait = 0;
            e_pd = '0; e_gid = '0; e_act = 1'b0;
        end else begin
            case (m_phase)
                0: if (!tx_busy && req_valid != '0) begin
                    w = -1;
                    for (int k = 0; k < N; k++)
                        if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                    e_ack[w] = 1'b1; e_dv = 1'b1; e_act = 1'b1;
                    e_pd = req_data[w*DW +: DW]; e_gid = IW'(w); m_phase = 1;
                end
                1: begin m_phase = 2; m_wait = 0; end
                2: if (tx_busy) m_phase = 3;
                   else begin
                       m_wait++;
                       if (m_wait == BT) begin
                           e_to = 1'b1; e_act = 1'b0; m_ptr = (int'(e_gid) + 1) % N; m_phase = 0;
                       end
                   end
                3: if (!tx_busy) begin e_act = 1'b0; m_ptr = (int'(e_gid) + 1) % N; m_phase = 0; end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_ack"},   32'(req_ack),       32'(e_ack));
        chk({tag, "_dv"},    32'(tx_data_valid), 32'(e_dv));
        chk({tag, "_pdata"}, 32'(tx_p_data),     32'(e_pd));
        chk({tag, "_gid"},   32'(grant_id),      32'(e_gid));
        chk({tag, "_active"},32'(active),        32'(e_act));
        chk({tag, "_tmo"},   32'(timeout_err),   32'(e_to));
    endtask

    // Drive one cycle of inputs at the falling edge, let the rising edge pass, return at the next falling edge
    task automatic apply(input logic r, input logic [N-1:0] rv, input logic b);
        RST = r; req_valid = rv; tx_busy = b;
        model_step();
        @(posedge CLK);
        @(negedge CLK);
        cyc++;
    endtask

    task automatic set_data(input logic [DW-1:0] d0, d1, d2, d3);
        req_data = {d3, d2, d1, d0};
    endtask

    logic [DW-1:0] seen[$];
    logic [DW-1:0] fair_exp[5];
    int            dvc, last_dv, n;
    logic          r, b;
    logic [N-1:0]  rv;

    initial begin
        RST = 1'b0; req_valid = '0; tx_busy = 1'b0; req_data = '0;
        fair_exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};

        // Directed table: reset, single grant, skip/wrap, external busy in idle
        set_data(8'hC0, 8'hB1, 8'hA5, 8'hD3);
        tbl.push_back(mk(0, 4'hF, 0, 4'h0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 4'hF, 0, 4'h0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 4'hF, 0, 4'h0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, 4'hF, 0, 4'h1, 1, 8'hC0, 0, 1, 0));
        tbl.push_back(mk(1, 4'h0, 0, 4'h0, 0, 8'hC0, 0, 1, 0));
        tbl.push_back(mk(1, 4'h0, 1, 4'h0, 0, 8'hC0, 0, 1, 0));
        tbl.push_back(mk(1, 4'h0, 1, 4'h0, 0, 8'hC0, 0, 1, 0));
        tbl.push_back(mk(1, 4'h0, 0, 4'h0, 0, 8'hC0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h4, 0, 4'h4, 1, 8'hA5, 2, 1, 0));
        tbl.push_back(mk(1, 4'h0, 0, 4'h0, 0, 8'hA5, 2, 1, 0));
        tbl.push_back(mk(1, 4'h0, 1, 4'h0, 0, 8'hA5, 2, 1, 0));
        tbl.push_back(mk(1, 4'h0, 1, 4'h0, 0, 8'hA5, 2, 1, 0));
        tbl.push_back(mk(1, 4'h0, 0, 4'h0, 0, 8'hA5, 2, 0, 0));
        tbl.push_back(mk(1, 4'h3, 0, 4'h1, 1, 8'hC0, 0, 1, 0));
        tbl.push_back(mk(1, 4'h2, 0, 4'h0, 0, 8'hC0, 0, 1, 0));
        tbl.push_back(mk(1, 4'h2, 1, 4'h0, 0, 8'hC0, 0, 1, 0));
        tbl.push_back(mk(1, 4'h2, 0, 4'h0, 0, 8'hC0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h2, 0, 4'h2, 1, 8'hB1, 1, 1, 0));
        tbl.push_back(mk(1, 4'h0, 0, 4'h0, 0, 8'hB1, 1, 1, 0));
        tbl.push_back(mk(1, 4'h0, 1, 4'h0, 0, 8'hB1, 1, 1, 0));
        tbl.push_back(mk(1, 4'h0, 0, 4'h0, 0, 8'hB1, 1, 0, 0));
        tbl.push_back(mk(1, 4'hF, 0, 4'h4, 1, 8'hA5, 2, 1, 0));
        tbl.push_back(mk(1, 4'h0, 0, 4'h0, 0, 8'hA5, 2, 1, 0));
        tbl.push_back(mk(1, 4'h0, 1, 4'h0, 0, 8'hA5, 2, 1, 0));
        tbl.push_back(mk(1, 4'h0, 0, 4'h0, 0, 8'hA5, 2, 0, 0));
        tbl.push_back(mk(1, 4'h1, 1, 4'h0, 0, 8'hA5, 2, 0, 0));
        tbl.push_back(mk(1, 4'h1, 1, 4'h0, 0, 8'hA5, 2, 0, 0));
        tbl.push_back(mk(1, 4'h1, 0, 4'h1, 1, 8'hC0, 0, 1, 0));
        tbl.push_back(mk(1, 4'h0, 0, 4'h0, 0, 8'hC0, 0, 1, 0));
        tbl.push_back(mk(1, 4'h0, 1, 4'h0, 0, 8'hC0, 0, 1, 0));
        tbl.push_back(mk(1, 4'h0, 0, 4'h0, 0, 8'hC0, 0, 0, 0));
        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].rv, tbl[i].busy);
            chk($sformatf("t%0d_ack", i),    32'(req_ack),       32'(tbl[i].ack));
            chk($sformatf("t%0d_dv", i),     32'(tx_data_valid), 32'(tbl[i].dv));
            chk($sformatf("t%0d_pdata", i),  32'(tx_p_data),     32'(tbl[i].pd));
            chk($sformatf("t%0d_gid", i),    32'(grant_id),      32'(tbl[i].gid));
            chk($sformatf("t%0d_active", i), 32'(active),        32'(tbl[i].act));
            chk($sformatf("t%0d_tmo", i),    32'(timeout_err),   32'(tbl[i].to));
        end

        // Fairness: all four requesting continuously, emulated transmitter with FL-cycle frames
        set_data(8'h10, 8'h11, 8'h12, 8'h13);
        apply(0, '0, 0);
        dvc = -1000; last_dv = -1000;
        for (int c = 0; c < 200 && seen.size() < 5; c++) begin
            apply(1, 4'hF, (cyc >= dvc + 1 && cyc < dvc + 1 + FL));
            check_model("fair");
            if (tx_data_valid) begin
                if (last_dv >= 0) chk("fair_gap_ok", 32'(cyc - last_dv >= FL + 2), 32'd1);
                last_dv = cyc; dvc = cyc;
                seen.push_back(tx_p_data);
            end
        end
        chk("fair_frames", 32'(seen.size()), 32'd5);
        for (int i = 0; i < seen.size() && i < 5; i++)
            chk($sformatf("fair_order%0d", i), 32'(seen[i]), 32'(fair_exp[i]));

        // Timeout: busy never rises; pulse lands BT cycles after leaving ISSUE
        apply(0, '0, 0);
        apply(1, 4'b0010, 0);
        check_model("tmo");
        chk("tmo_dv", 32'(tx_data_valid), 32'd1);
        n = 0;
        for (int c = 0; c < BT + 4 && !timeout_err; c++) begin
            apply(1, '0, 0);
            check_model("tmo");
            n++;
        end
        chk("tmo_cycles", 32'(n), 32'(BT + 1));
        chk("tmo_active", 32'(active), 32'd0);
        apply(1, 4'b0100, 0);
        check_model("tmo");
        chk("tmo_next_ack", 32'(req_ack), 32'b0100);

        // Mid-frame reset: pointer must return to requester 0
        set_data(8'h21, 8'h22, 8'h23, 8'h24);
        apply(0, '0, 0);
        apply(1, 4'b0001, 0); check_model("mr");
        apply(1, '0, 0); apply(1, '0, 1); apply(1, '0, 0); check_model("mr");
        apply(1, 4'b0010, 0); check_model("mr");
        chk("mr_ack1", 32'(req_ack), 32'b0010);
        apply(1, '0, 0); apply(1, '0, 1); apply(1, '0, 1);
        chk("mr_active_pre", 32'(active), 32'd1);
        apply(0, 4'b0011, 1);
        check_model("mr");
        chk("mr_rst_active", 32'(active), 32'd0);
        chk("mr_rst_gid", 32'(grant_id), 32'd0);
        chk("mr_rst_pdata", 32'(tx_p_data), 32'd0);
        apply(1, 4'b0011, 0);
        check_model("mr");
        chk("mr_rearb_ack", 32'(req_ack), 32'b0001);
        chk("mr_rearb_pdata", 32'(tx_p_data), 32'h21);

        // Randomized traffic against the reference model
        apply(0, '0, 0);
        dvc = -1000; n = 0;
        last_dv = 0;
        rv = '0;
        for (int c = 0; c < 3000; c++) begin
            r  = ($urandom_range(0, 299) != 0);
            rv = req_valid;
            for (int i = 0; i < N; i++) begin
                if (!rv[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        rv[i] = 1'b1;
                        req_data[i*DW +: DW] = DW'($urandom);
                    end
                end else if ($urandom_range(0, 49) == 0) begin
                    rv[i] = 1'b0;
                end
            end
            b = (cyc >= dvc + 1 + n && cyc < dvc + 1 + n + last_dv) || ($urandom_range(0, 39) == 0);
            apply(r, rv, b);
            check_model("rnd");
            if (!r) dvc = -100000;
            if (tx_data_valid) begin
                dvc     = cyc;
                n       = ($urandom_range(0, 9) == 0) ? 100000 : int'($urandom_range(0, 2));
                last_dv = int'($urandom_range(2, 6));
            end
            req_valid = req_valid & ~req_ack;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
